// File: rtl/mem_bus_arbiter.sv
// Fixed-priority arbiter sharing one synchronous memory bus between instruction fetch and data memory.
// Grants are registered, held until ack or watchdog expiry, and completions are returned as one-cycle ready pulses.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        dm_ce_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_i,
  output logic [31:0] dm_data_o,
  output logic        dm_ready_o,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUS,
    DM_BUS,
    RESP
  } state_t;

  localparam bit         WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  wd_cnt;
  logic        timed_out;
  logic        done;
  logic [31:0] rsp_data;

  // A watchdog expiry behaves like an ack carrying zero; a real ack in the same cycle wins.
  always_comb begin
    timed_out = WD_EN && (wd_cnt == WD_LAST) && !bus_ack_i;
    done      = bus_ack_i || timed_out;
    rsp_data  = bus_ack_i ? bus_data_i : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wd_cnt     <= 8'h0;
      bus_req_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_sel_o  <= 4'h0;
      bus_addr_o <= 32'h0;
      bus_data_o <= 32'h0;
      if_data_o  <= 32'h0;
      dm_data_o  <= 32'h0;
      if_ready_o <= 1'b0;
      dm_ready_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if_ready_o <= 1'b0;
      dm_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_ce_i) begin
            bus_req_o  <= 1'b1;
            bus_we_o   <= dm_we_i;
            bus_sel_o  <= dm_sel_i;
            bus_addr_o <= dm_addr_i;
            bus_data_o <= dm_data_i;
            state      <= DM_BUS;
          end else if (if_ce_i) begin
            bus_req_o  <= 1'b1;
            bus_we_o   <= 1'b0;
            bus_sel_o  <= 4'b1111;
            bus_addr_o <= if_addr_i;
            bus_data_o <= 32'h0;
            state      <= IF_BUS;
          end
        end
        IF_BUS, DM_BUS: begin
          if (done) begin
            bus_req_o <= 1'b0;
            wd_cnt    <= 8'h0;
            state     <= RESP;
            if (timed_out) err_o <= 1'b1;
            if (state == IF_BUS) begin
              if_data_o  <= rsp_data;
              if_ready_o <= 1'b1;
            end else begin
              if (!bus_we_o) dm_data_o <= rsp_data;
              dm_ready_o <= 1'b1;
            end
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        // One dead cycle so requesters can drop or advance ce before it is sampled again.
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stallreq_if_o  = if_ce_i & ~if_ready_o;
  assign stallreq_mem_o = dm_ce_i & ~dm_ready_o;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_ce_i = 1'b0;
  logic [31:0] if_addr_i = 32'h0;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        dm_ce_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [3:0]  dm_sel_i = 4'h0;
  logic [31:0] dm_addr_i = 32'h0;
  logic [31:0] dm_data_i = 32'h0;
  logic [31:0] dm_data_o;
  logic        dm_ready_o;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i = 32'h0;
  logic        bus_ack_i = 1'b0;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
    .dm_ce_i(dm_ce_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
    .dm_data_i(dm_data_i), .dm_data_o(dm_data_o), .dm_ready_o(dm_ready_o),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o), .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Transaction-level model: owner 0 = none, 1 = fetch, 2 = data; in_resp marks the pulse cycle.
  int          m_owner = 0;
  int          m_waited = 0;
  bit          m_in_resp = 1'b0;
  bit          m_req = 1'b0, m_we = 1'b0;
  logic [3:0]  m_sel = 4'h0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_if_data = 32'h0, m_dm_data = 32'h0;
  bit          m_if_rdy = 1'b0, m_dm_rdy = 1'b0, m_err = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = 0; m_waited = 0; m_in_resp = 0; m_req = 0; m_we = 0; m_sel = 4'h0;
      m_addr = 32'h0; m_wdata = 32'h0; m_if_data = 32'h0; m_dm_data = 32'h0;
      m_if_rdy = 0; m_dm_rdy = 0; m_err = 0;
    end else begin
      m_if_rdy = 0;
      m_dm_rdy = 0;
      if (m_in_resp) begin
        m_in_resp = 0;
      end else if (m_owner != 0) begin
        if (bus_ack_i || m_waited == TO - 1) begin
          if (m_owner == 1) begin
            m_if_data = bus_ack_i ? bus_data_i : 32'h0;
            m_if_rdy  = 1;
          end else begin
            if (!m_we) m_dm_data = bus_ack_i ? bus_data_i : 32'h0;
            m_dm_rdy = 1;
          end
          if (!bus_ack_i) m_err = 1;
          m_owner = 0; m_req = 0; m_waited = 0; m_in_resp = 1;
        end else begin
          m_waited++;
        end
      end else if (dm_ce_i) begin
        m_owner = 2; m_req = 1; m_we = dm_we_i; m_sel = dm_sel_i;
        m_addr = dm_addr_i; m_wdata = dm_data_i;
      end else if (if_ce_i) begin
        m_owner = 1; m_req = 1; m_we = 0; m_sel = 4'hf;
        m_addr = if_addr_i; m_wdata = 32'h0;
      end
    end
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("bus_req", 32'(bus_req_o), 32'(m_req));
    if (m_req) begin
      checkValue("bus_we", 32'(bus_we_o), 32'(m_we));
      checkValue("bus_sel", 32'(bus_sel_o), 32'(m_sel));
      checkValue("bus_addr", bus_addr_o, m_addr);
      checkValue("bus_wdata", bus_data_o, m_wdata);
    end
    checkValue("if_ready", 32'(if_ready_o), 32'(m_if_rdy));
    checkValue("dm_ready", 32'(dm_ready_o), 32'(m_dm_rdy));
    checkValue("if_data", if_data_o, m_if_data);
    checkValue("dm_data", dm_data_o, m_dm_data);
    checkValue("err", 32'(err_o), 32'(m_err));
    checkValue("stall_if", 32'(stallreq_if_o), 32'(if_ce_i & ~m_if_rdy));
    checkValue("stall_mem", 32'(stallreq_mem_o), 32'(dm_ce_i & ~m_dm_rdy));
  endtask

  always @(negedge clk) checkOutput();

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    if (m_if_rdy) begin
      if_ce_i = ($urandom_range(0, 1) == 1);
      if_addr_i = $urandom;
    end else if (!if_ce_i) begin
      if ($urandom_range(0, 3) == 0) begin
        if_ce_i = 1'b1;
        if_addr_i = $urandom;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      if_addr_i = $urandom;
    end
    if (m_dm_rdy || (!dm_ce_i && $urandom_range(0, 3) == 0)) begin
      dm_ce_i = m_dm_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      dm_we_i = $urandom_range(0, 1) == 1;
      dm_sel_i = 4'($urandom);
      dm_addr_i = $urandom;
      dm_data_i = $urandom;
    end else if (dm_ce_i && $urandom_range(0, 7) == 0) begin
      dm_addr_i = $urandom;
      dm_data_i = $urandom;
    end
    bus_ack_i = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
    bus_data_i = $urandom;
  endtask

  task automatic fetchOnly();
    step(); if_ce_i = 1'b1; if_addr_i = 32'h100; bus_ack_i = 1'b0; #1;
    checkValue("fetch stall c0", 32'(stallreq_if_o), 32'h1);
    step();
    checkValue("fetch req c1", 32'(bus_req_o), 32'h1);
    checkValue("fetch sel c1", 32'(bus_sel_o), 32'hf);
    checkValue("fetch we c1", 32'(bus_we_o), 32'h0);
    checkValue("fetch addr c1", bus_addr_o, 32'h100);
    checkValue("fetch stall c1", 32'(stallreq_if_o), 32'h1);
    bus_ack_i = 1'b1; bus_data_i = 32'h0000_0013;
    step();
    checkValue("fetch ready c2", 32'(if_ready_o), 32'h1);
    checkValue("fetch data c2", if_data_o, 32'h0000_0013);
    checkValue("fetch stall c2", 32'(stallreq_if_o), 32'h0);
    bus_ack_i = 1'b0; if_ce_i = 1'b0;
    step();
    checkValue("fetch idle c3", 32'(bus_req_o | if_ready_o), 32'h0);
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b1;
    step();
    checkValue("reset req", 32'(bus_req_o), 32'h0);
    checkValue("reset err", 32'(err_o), 32'h0);

    fetchOnly();

    // Contention: data load wins, fetch follows after the RESP cycle.
    step();
    if_ce_i = 1'b1; if_addr_i = 32'h300;
    dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'b0010; dm_addr_i = 32'h204; dm_data_i = 32'h0;
    step();
    checkValue("cont dm addr", bus_addr_o, 32'h204);
    checkValue("cont dm sel", 32'(bus_sel_o), 32'h2);
    step(); bus_ack_i = 1'b1; bus_data_i = 32'hCAFE_0001;
    step(); bus_ack_i = 1'b0;
    checkValue("cont dm ready c3", 32'(dm_ready_o), 32'h1);
    checkValue("cont dm data c3", dm_data_o, 32'hCAFE_0001);
    checkValue("cont if wait c3", 32'(if_ready_o), 32'h0);
    dm_ce_i = 1'b0;
    step();
    checkValue("cont idle c4", 32'(bus_req_o), 32'h0);
    step();
    checkValue("cont if addr c5", bus_addr_o, 32'h300);
    step(); bus_ack_i = 1'b1; bus_data_i = 32'h00A0_0093;
    step(); bus_ack_i = 1'b0;
    checkValue("cont if ready c7", 32'(if_ready_o), 32'h1);
    checkValue("cont if data c7", if_data_o, 32'h00A0_0093);
    if_ce_i = 1'b0;

    // Store leaves load data untouched.
    step();
    dm_ce_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'b1100; dm_addr_i = 32'h8; dm_data_i = 32'hABCD_0000;
    step();
    checkValue("store we", 32'(bus_we_o), 32'h1);
    checkValue("store wdata", bus_data_o, 32'hABCD_0000);
    bus_ack_i = 1'b1; bus_data_i = 32'h5555_5555;
    step(); bus_ack_i = 1'b0;
    checkValue("store ready", 32'(dm_ready_o), 32'h1);
    checkValue("store keeps data", dm_data_o, 32'hCAFE_0001);
    dm_ce_i = 1'b0; dm_we_i = 1'b0;

    // Watchdog expiry on a load.
    step();
    dm_ce_i = 1'b1; dm_sel_i = 4'hf; dm_addr_i = 32'h40;
    for (int i = 1; i <= TO; i++) begin
      step();
      checkValue($sformatf("timeout req c%0d", i), 32'(bus_req_o), 32'h1);
    end
    step();
    checkValue("timeout ready", 32'(dm_ready_o), 32'h1);
    checkValue("timeout data", dm_data_o, 32'h0);
    checkValue("timeout err", 32'(err_o), 32'h1);
    dm_ce_i = 1'b0;
    fetchOnly();
    checkValue("err sticky", 32'(err_o), 32'h1);

    // Stray acks in IDLE and in RESP.
    step(); bus_ack_i = 1'b1;
    step();
    checkValue("stray idle", 32'(bus_req_o | if_ready_o | dm_ready_o), 32'h0);
    bus_ack_i = 1'b0; if_ce_i = 1'b1; if_addr_i = 32'h500;
    step(); bus_ack_i = 1'b1; bus_data_i = 32'h77;
    step(); if_ce_i = 1'b0;
    step();
    checkValue("stray resp", 32'(bus_req_o | if_ready_o | dm_ready_o), 32'h0);
    bus_ack_i = 1'b0;

    // Reset in the middle of a data transaction.
    step(); dm_ce_i = 1'b1; dm_addr_i = 32'h80;
    step();
    checkValue("mid req before reset", 32'(bus_req_o), 32'h1);
    #2 rst = 1'b0;
    #1;
    checkValue("mid reset req", 32'(bus_req_o), 32'h0);
    checkValue("mid reset err", 32'(err_o), 32'h0);
    checkValue("mid reset dm data", dm_data_o, 32'h0);
    checkValue("mid reset if data", if_data_o, 32'h0);
    dm_ce_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    checkValue("post reset ready", 32'(dm_ready_o | if_ready_o), 32'h0);
    fetchOnly();

    repeat (3000) begin
      step();
      applyStimulus();
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
